tile_buffer_sched: RTL and testbench

Job-level sequencer for the A/B/C tile buffer memory interface.
- For each tile it requests and counts a COLS-beat fill of buffer A, then of buffer B, from the shared memory read port.
- It then kicks the compute array and drains buffer C column by column.
- It owns all load/stream enables and column pointers, so the buffer block needs no free-running FSM of its own.

---
 rtl/tile_buffer_sched.sv | 210 +++++++++++++++++++++
 tb/tb_tile_buffer_sched.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tile_buffer_sched.sv
// -----------------------------------------------------------------------------
// tile_buffer_sched
//
// Job-level sequencer for the A/B/C tile buffer memory interface. For every
// tile of a job it requests and counts a COLS-beat fill of buffer A and then
// buffer B from the shared memory read port. It then kicks the compute array
// and drains buffer C one column per accepted beat. All load/stream enables
// and column pointers are owned here, so the buffer block itself is a plain
// memory with no control state.
//
// Optional feature macro: TILE_SCHED_PERF_EN
//   When defined, adds output stall_cycles, a saturating 32-bit count of
//   cycles spent waiting on mem_req_ready, mem_rvalid or drain_ready.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   start, num_tiles    job start pulse (sampled only when idle) and tile count
//   busy, done          job in progress / one-cycle completion pulse
//   mem_req_valid/_sel  burst request to the read port (sel 0=A, 1=B)
//   mem_req_ready       request accepted
//   mem_rvalid          read beat present this cycle
//   load_en_a/_b        write current beat into A/B at wr_col
//   wr_col              fill column pointer
//   compute_start       one-cycle pulse once both buffers are full
//   compute_done        compute finished, C valid
//   drain_valid/_ready  C column handshake, column given by rd_col
//   rd_col              drain column pointer
//   tile_idx            current tile, 0-based
//   stall_cycles        (TILE_SCHED_PERF_EN only) stall counter
// -----------------------------------------------------------------------------
module tile_buffer_sched #(
  parameter int COLS   = 64,
  parameter int PTR_W  = $clog2(COLS),
  parameter int TILE_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [TILE_W-1:0] num_tiles,
  output logic              busy,
  output logic              done,
  output logic              mem_req_valid,
  output logic              mem_req_sel,
  input  logic              mem_req_ready,
  input  logic              mem_rvalid,
  output logic              load_en_a,
  output logic              load_en_b,
  output logic [PTR_W-1:0]  wr_col,
  output logic              compute_start,
  input  logic              compute_done,
  output logic              drain_valid,
  input  logic              drain_ready,
  output logic [PTR_W-1:0]  rd_col,
  output logic [TILE_W-1:0] tile_idx
`ifdef TILE_SCHED_PERF_EN
  ,
  output logic [31:0]       stall_cycles
`endif
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_REQ_A   = 3'd1,
    S_LOAD_A  = 3'd2,
    S_REQ_B   = 3'd3,
    S_LOAD_B  = 3'd4,
    S_COMPUTE = 3'd5,
    S_WAIT_C  = 3'd6,
    S_DRAIN   = 3'd7
  } state_t;

  localparam logic [PTR_W-1:0] LAST_COL = PTR_W'(COLS - 1);

  state_t              r_state;
  state_t              w_state_next;
  logic [PTR_W-1:0]    r_wr_col;
  logic [PTR_W-1:0]    r_rd_col;
  logic [TILE_W-1:0]   r_tile_idx;
  logic [TILE_W-1:0]   r_count;
  logic                r_done;
  logic                r_compute_start;

  logic                w_start_ok;
  logic                w_start_zero;
  logic                w_fill_beat;
  logic                w_last_fill;
  logic                w_drain_beat;
  logic                w_last_drain;
  logic                w_last_tile;
  logic                w_done_next;
  logic                w_compute_start_next;

  // Shared event decodes used by both next-state and datapath logic.
  assign w_start_ok   = (r_state == S_IDLE) && start && (num_tiles != '0);
  assign w_start_zero = (r_state == S_IDLE) && start && (num_tiles == '0);
  assign w_fill_beat  = ((r_state == S_LOAD_A) || (r_state == S_LOAD_B)) && mem_rvalid;
  assign w_last_fill  = w_fill_beat && (r_wr_col == LAST_COL);
  assign w_drain_beat = (r_state == S_DRAIN) && drain_ready;
  assign w_last_drain = w_drain_beat && (r_rd_col == LAST_COL);
  assign w_last_tile  = (r_tile_idx == (r_count - TILE_W'(1)));

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:    if (w_start_ok) w_state_next = S_REQ_A;
      S_REQ_A:   if (mem_req_ready) w_state_next = S_LOAD_A;
      S_LOAD_A:  if (w_last_fill) w_state_next = S_REQ_B;
      S_REQ_B:   if (mem_req_ready) w_state_next = S_LOAD_B;
      S_LOAD_B:  if (w_last_fill) w_state_next = S_COMPUTE;
      S_COMPUTE: w_state_next = S_WAIT_C;
      S_WAIT_C:  if (compute_done) w_state_next = S_DRAIN;
      S_DRAIN: begin
        if (w_last_drain) begin
          w_state_next = w_last_tile ? S_IDLE : S_REQ_A;
        end
      end
      default:   w_state_next = S_IDLE;
    endcase
  end

  // Output decode. done/compute_start are computed here one cycle early and
  // registered below so they appear as clean single-cycle pulses.
  always_comb begin
    busy                 = (r_state != S_IDLE);
    mem_req_valid        = (r_state == S_REQ_A) || (r_state == S_REQ_B);
    mem_req_sel          = (r_state == S_REQ_B);
    load_en_a            = (r_state == S_LOAD_A) && mem_rvalid;
    load_en_b            = (r_state == S_LOAD_B) && mem_rvalid;
    drain_valid          = (r_state == S_DRAIN);
    w_done_next          = w_start_zero || (w_last_drain && w_last_tile);
    w_compute_start_next = (r_state == S_LOAD_B) && w_last_fill;
  end

  // Pulse registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_done          <= 1'b0;
      r_compute_start <= 1'b0;
    end else begin
      r_done          <= w_done_next;
      r_compute_start <= w_compute_start_next;
    end
  end

  // Column pointers, tile index and latched tile count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_col   <= '0;
      r_rd_col   <= '0;
      r_tile_idx <= '0;
      r_count    <= '0;
    end else begin
      if (w_start_ok) begin
        r_count    <= num_tiles;
        r_tile_idx <= '0;
        r_wr_col   <= '0;
        r_rd_col   <= '0;
      end
      if (w_fill_beat) begin
        r_wr_col <= w_last_fill ? '0 : r_wr_col + PTR_W'(1);
      end
      if (w_drain_beat) begin
        r_rd_col <= w_last_drain ? '0 : r_rd_col + PTR_W'(1);
      end
      // The index stays on the final tile after completion.
      if (w_last_drain && !w_last_tile) begin
        r_tile_idx <= r_tile_idx + TILE_W'(1);
      end
    end
  end

  assign done          = r_done;
  assign compute_start = r_compute_start;
  assign wr_col        = r_wr_col;
  assign rd_col        = r_rd_col;
  assign tile_idx      = r_tile_idx;

`ifdef TILE_SCHED_PERF_EN
  logic [31:0] r_stall_cycles;
  logic        w_stall;

  assign w_stall = (mem_req_valid && !mem_req_ready) ||
                   (((r_state == S_LOAD_A) || (r_state == S_LOAD_B)) && !mem_rvalid) ||
                   ((r_state == S_DRAIN) && !drain_ready);

  // Cleared on any accepted start (including a zero-tile job); saturates.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cycles <= '0;
    end else if (w_start_ok || w_start_zero) begin
      r_stall_cycles <= '0;
    end else if (w_stall && (r_stall_cycles != '1)) begin
      r_stall_cycles <= r_stall_cycles + 32'd1;
    end
  end

  assign stall_cycles = r_stall_cycles;
`endif

endmodule

// File: tb/tb_tile_buffer_sched.sv
module tb_tile_buffer_sched;

  localparam int COLS   = 4;
  localparam int PTR_W  = 2;
  localparam int TILE_W = 8;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic [TILE_W-1:0] num_tiles = '0;
  logic              busy;
  logic              done;
  logic              mem_req_valid;
  logic              mem_req_sel;
  logic              mem_req_ready = 1'b0;
  logic              mem_rvalid = 1'b0;
  logic              load_en_a;
  logic              load_en_b;
  logic [PTR_W-1:0]  wr_col;
  logic              compute_start;
  logic              compute_done = 1'b0;
  logic              drain_valid;
  logic              drain_ready = 1'b0;
  logic [PTR_W-1:0]  rd_col;
  logic [TILE_W-1:0] tile_idx;
`ifdef TILE_SCHED_PERF_EN
  logic [31:0]       stall_cycles;
`endif

  int n_chk = 0;
  int n_err = 0;

  // Event counters for the multi-tile run
  logic cnt_clr = 1'b1;
  int   cnt_a, cnt_b, cnt_d, cnt_done, cnt_cs;

  always #5 clk = ~clk;

  tile_buffer_sched #(.COLS(COLS), .PTR_W(PTR_W), .TILE_W(TILE_W)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .num_tiles     (num_tiles),
    .busy          (busy),
    .done          (done),
    .mem_req_valid (mem_req_valid),
    .mem_req_sel   (mem_req_sel),
    .mem_req_ready (mem_req_ready),
    .mem_rvalid    (mem_rvalid),
    .load_en_a     (load_en_a),
    .load_en_b     (load_en_b),
    .wr_col        (wr_col),
    .compute_start (compute_start),
    .compute_done  (compute_done),
    .drain_valid   (drain_valid),
    .drain_ready   (drain_ready),
    .rd_col        (rd_col),
    .tile_idx      (tile_idx)
`ifdef TILE_SCHED_PERF_EN
    ,
    .stall_cycles  (stall_cycles)
`endif
  );

  always @(posedge clk) begin
    if (cnt_clr) begin
      cnt_a = 0; cnt_b = 0; cnt_d = 0; cnt_done = 0; cnt_cs = 0;
    end else begin
      if (load_en_a) cnt_a = cnt_a + 1;
      if (load_en_b) cnt_b = cnt_b + 1;
      if (drain_valid && drain_ready) cnt_d = cnt_d + 1;
      if (done) cnt_done = cnt_done + 1;
      if (compute_start) cnt_cs = cnt_cs + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    assert (act === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called with the DUT in REQ_A of tile t and all ready inputs high.
  // Returns with the DUT sampled on the last drain beat of the tile.
  task automatic run_tile(input int t, input int cdelay);
    chk("reqa_valid", mem_req_valid, 1);
    chk("reqa_sel", mem_req_sel, 0);
    chk("tile_idx", tile_idx, t);
    tick();
    for (int i = 0; i < COLS; i++) begin
      chk("load_en_a", load_en_a, 1);
      chk("load_a_wr_col", wr_col, i);
      chk("load_a_en_b", load_en_b, 0);
      chk("load_a_drain_valid", drain_valid, 0);
      tick();
    end
    chk("reqb_valid", mem_req_valid, 1);
    chk("reqb_sel", mem_req_sel, 1);
    tick();
    for (int i = 0; i < COLS; i++) begin
      chk("load_en_b", load_en_b, 1);
      chk("load_b_wr_col", wr_col, i);
      chk("load_b_en_a", load_en_a, 0);
      chk("load_b_drain_valid", drain_valid, 0);
      tick();
    end
    chk("compute_start", compute_start, 1);
    tick();
    chk("compute_start_off", compute_start, 0);
    repeat (cdelay - 1) begin
      tick();
      chk("wait_c_no_drain", drain_valid, 0);
    end
    compute_done = 1'b1;
    tick();
    compute_done = 1'b0;
    for (int i = 0; i < COLS; i++) begin
      chk("drain_valid", drain_valid, 1);
      chk("drain_rd_col", rd_col, i);
      chk("drain_no_load", load_en_a | load_en_b, 0);
      if (i < COLS - 1) tick();
    end
  endtask

  initial begin
    logic pat [7];
    int   beats;

    // ---- reset values ----
    #2;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_req_valid", mem_req_valid, 0);
    chk("rst_wr_col", wr_col, 0);
    chk("rst_rd_col", rd_col, 0);
    chk("rst_tile_idx", tile_idx, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // ---- single tile, compute_done 3 cycles after compute_start ----
    mem_req_ready = 1'b1; mem_rvalid = 1'b1; drain_ready = 1'b1;
    start = 1'b1; num_tiles = 8'd1;
    tick();
    start = 1'b0;
    chk("t1_busy", busy, 1);
    run_tile(0, 3);
    tick();
    chk("t1_done", done, 1);
    chk("t1_busy_low", busy, 0);
    tick();
    chk("t1_done_clear", done, 0);

    // ---- three tiles; start and num_tiles changes while busy ignored ----
    cnt_clr = 1'b0;
    start = 1'b1; num_tiles = 8'd3;
    tick();
    start = 1'b0; num_tiles = 8'd0;
    run_tile(0, 1);
    tick();
    start = 1'b1; num_tiles = 8'd9;
    run_tile(1, 1);
    start = 1'b0;
    tick();
    run_tile(2, 2);
    tick();
    chk("t3_done", done, 1);
    chk("t3_busy_low", busy, 0);
    tick();
    cnt_clr = 1'b1;
    chk("t3_a_beats", cnt_a, 12);
    chk("t3_b_beats", cnt_b, 12);
    chk("t3_drain_beats", cnt_d, 12);
    chk("t3_done_pulses", cnt_done, 1);
    chk("t3_compute_pulses", cnt_cs, 3);

    // ---- zero-tile job ----
    start = 1'b1; num_tiles = 8'd0;
    tick();
    start = 1'b0;
    chk("z_busy", busy, 0);
    chk("z_done", done, 1);
    chk("z_req_valid", mem_req_valid, 0);
    tick();
    chk("z_done_clear", done, 0);
    chk("z_req_valid2", mem_req_valid, 0);

    // ---- gapped mem_rvalid in LOAD_A, then reset during LOAD_B ----
    pat[0] = 1; pat[1] = 0; pat[2] = 0; pat[3] = 1; pat[4] = 1; pat[5] = 0; pat[6] = 1;
    mem_rvalid = 1'b0;
    start = 1'b1; num_tiles = 8'd1;
    tick();
    start = 1'b0;
    tick();
    beats = 0;
    for (int k = 0; k < 7; k++) begin
      mem_rvalid = pat[k];
      #1;
      chk("gap_load_en_a", load_en_a, pat[k]);
      chk("gap_wr_col", wr_col, beats);
      chk("gap_in_load_a", mem_req_valid, 0);
      if (pat[k]) beats++;
      tick();
    end
    chk("gap_reqb_valid", mem_req_valid, 1);
    chk("gap_reqb_sel", mem_req_sel, 1);
    mem_req_ready = 1'b0; mem_rvalid = 1'b1;
    #1;
    chk("req_rvalid_no_en", load_en_a | load_en_b, 0);
    tick();
    chk("req_rvalid_wr_col", wr_col, 0);
    chk("req_hold", mem_req_valid, 1);
    mem_req_ready = 1'b1;
    tick();
    tick();
    tick();
    chk("lb_wr_col2", wr_col, 2);
    chk("lb_en_b", load_en_b, 1);
    rst_n = 1'b0;
    #1;
    chk("ar_busy", busy, 0);
    chk("ar_load_en_b", load_en_b, 0);
    chk("ar_wr_col", wr_col, 0);
    chk("ar_req_valid", mem_req_valid, 0);
    chk("ar_done", done, 0);
    chk("ar_drain_valid", drain_valid, 0);
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b1;
    tick();
    chk("ar_no_done", done, 0);
    start = 1'b1; num_tiles = 8'd1;
    tick();
    start = 1'b0;
    run_tile(0, 1);
    tick();
    chk("ar_job_done", done, 1);

`ifdef TILE_SCHED_PERF_EN
    // ---- stall counter: 2+2 request stalls, 5 drain stalls ----
    tick();
    mem_req_ready = 1'b0; drain_ready = 1'b0;
    start = 1'b1; num_tiles = 8'd1;
    tick();
    start = 1'b0;
    chk("perf_cleared", stall_cycles, 0);
    repeat (2) tick();
    mem_req_ready = 1'b1;
    tick();
    repeat (COLS) tick();
    mem_req_ready = 1'b0;
    repeat (2) tick();
    mem_req_ready = 1'b1;
    tick();
    repeat (COLS) tick();
    chk("perf_compute", compute_start, 1);
    compute_done = 1'b1;
    tick();
    tick();
    compute_done = 1'b0;
    chk("perf_in_drain", drain_valid, 1);
    repeat (5) tick();
    drain_ready = 1'b1;
    repeat (COLS) tick();
    chk("perf_done", done, 1);
    chk("perf_stalls", stall_cycles, 9);
    tick();
    chk("perf_hold", stall_cycles, 9);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
